adc_frame_sequencer: RTL and testbench
======================================

Name: adc_frame_sequencer

Overview:
- Schedules periodic ADC sample sets.
- Emits a one-cycle conversion request to the ADS8528 driver every SAMPLE_PERIOD clocks.
- Collects the N_CH per-channel samples that the driver streams back (valid-only, no backpressure) into one frame, tags it with a sequence number, and buffers it in a FIFO.
- Presents frames downstream on a ready/valid handshake, which adds the backpressure the driver lacks.

Parameters:
- N_CH, 4, samples per frame; range 1..8.
- DATA_W, 16, bits per sample.
- PERIOD_W, 24, width of the sample_period input.
- TIMEOUT, 256, max clocks from conv_req to last sample before the frame is aborted.
- FIFO_DEPTH, 4, frames buffered; power of 2, ≥2.
- SEQ_W, 16, width of the frame sequence number.

Ports:
- clk  in  1  system clock
- sresetn  in  1  synchronous reset, active-low
- enable  in  1  1 = run sampling; 0 = stop issuing requests
- sample_period  in  PERIOD_W  clocks between conv_req pulses; values <2 treated as 2
- conv_req  out  1  one-cycle pulse; starts one ADC conversion set
- sample_data  in  DATA_W  sample from the ADC driver
- sample_valid  in  1  sample_data valid this cycle (no ready)
- frame_data  out  N_CH*DATA_W  channel 0 in LSBs
- frame_seq  out  SEQ_W  sequence number of frame_data
- frame_valid  out  1  frame available
- frame_ready  in  1  consumer accepts frame
- overrun_count  out  16  frames dropped because the FIFO was full; saturating
- timeout_count  out  16  frames aborted on timeout; saturating
- missed_count  out  16  triggers skipped because a frame was still collecting; saturating
- active  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0 on sresetn=0 at the clk edge. State → IDLE; FIFO empty; timer, channel index, sequence and all counters cleared.
- Reset mid-operation: partial frame and all FIFO contents discarded; no frame_valid in the cycle after reset.
- States:
  - IDLE → ARMED when enable=1. Timer loads 0; conv_req fires on the first ARMED cycle.
  - ARMED: timer counts up. When timer reaches max(sample_period,2)-1, or on the entry cycle, assert conv_req for 1 cycle, clear timer and channel index, start the timeout counter, go to COLLECT.
  - COLLECT: each sample_valid writes sample_data into slot[ch_idx], then ch_idx++.
    - On the valid with ch_idx==N_CH-1: push {seq, slots} to the FIFO (frame complete the cycle after the final sample), seq++ with wrap, → ARMED.
    - Timeout counter reaching TIMEOUT without completion: drop the partial frame, timeout_count++, seq not incremented, → ARMED.
- Period timer runs in COLLECT too, so the period is measured conv_req to conv_req. If it expires while still in COLLECT: no conv_req, missed_count++, timer reloads.
- Stray input: sample_valid in IDLE or ARMED is ignored.
- enable deasserted: finish any COLLECT in progress (complete or timeout), then → IDLE instead of ARMED. The FIFO continues draining.
- Full FIFO: a completed frame is dropped, overrun_count++, and seq still increments, so the consumer sees a gap.
- Simultaneous push and pop on a full FIFO: the push is accepted.
- Output handshake:
  - frame_valid = FIFO non-empty. A transfer occurs when frame_valid & frame_ready.
  - frame_data and frame_seq stay stable while frame_valid=1 & frame_ready=0.
  - Zero-latency show-ahead FIFO head.
- Counters saturate at 16'hFFFF; they clear only on reset.
- frame_seq wraps 2^SEQ_W-1 → 0.

Decomposition:
- Package adc_pkg:
  - ADC_DATA_W=16
  - typedef seq_state_t {IDLE, ARMED, COLLECT}
  - saturating-increment function, shared with the other ADC blocks
- Sub-module sync_fifo (WIDTH=SEQ_W+N_CH*DATA_W, DEPTH=FIFO_DEPTH):
  - show-ahead, full/empty flags, same clk/sresetn
- Top module holds the FSM, timer, timeout counter and slot registers.

Test Plan:
- Basic frame: N_CH=4, sample_period=100, enable=1, driver model returns 16'h1111, 16'h2222, 16'h3333, 16'h4444 20 clocks after each conv_req. Required: conv_req pulses exactly 100 clocks apart; frame_data=64'h4444_3333_2222_1111; frame_seq 0, 1, 2 …; all counters 0.
- Backpressure/overrun: frame_ready=0, FIFO_DEPTH=4, 6 frames produced. Required: frame_valid high after the first frame; overrun_count=2; on then raising frame_ready, seq 0, 1, 2, 3 delivered in order with stable data while stalled.
- Timeout: driver supplies only 3 samples, TIMEOUT=256. Required: no frame pushed; timeout_count=1; the next complete frame carries the unchanged seq.
- Missed trigger: sample_period=10, samples arrive 15 clocks after conv_req. Required: missed_count increments once per overlap; no conv_req issued while in COLLECT.
- Disable and reset:
  - enable dropped mid-COLLECT → frame completes, active falls the cycle after entering IDLE, no further conv_req.
  - sresetn=0 with 2 frames queued → frame_valid=0 and all counters 0 the next cycle.
- Boundaries:
  - sample_period=0 and 1 → conv_req every 2 clocks.
  - seq wraps: SEQ_W=2 gives 3 → 0.
  - Simultaneous push and pop on a full FIFO → no overrun.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared ADC definitions: sample width, frame sequencer state encoding and
// the saturating 16-bit event-counter increment used across the ADC blocks.
package adc_pkg;

    localparam int ADC_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        COLLECT = 2'd2
    } seq_state_t;

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO: rdata always shows the head entry while
// empty=0, with no read latency.
// Ports:
//   clk, sresetn   clock, synchronous active-low reset (empties the FIFO)
//   push, wdata    write request/data; accepted when not full or when a pop
//                  happens in the same cycle
//   pop            remove the head entry (ignored while empty)
//   rdata          head entry
//   full, empty    occupancy flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             sresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A pop frees the slot the push lands in, so full+pop still accepts.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adc_frame_sequencer.sv
// ADC frame sequencer: issues a conversion request every sample_period
// clocks, gathers the N_CH samples streamed back into one frame tagged with
// a sequence number, and queues frames for a ready/valid consumer.
// Ports:
//   clk, sresetn        clock, synchronous active-low reset
//   enable              run periodic sampling
//   sample_period       clocks between conv_req pulses (values < 2 act as 2)
//   conv_req            one-cycle conversion request to the ADC driver
//   sample_data/valid   per-channel sample stream from the driver
//   frame_data/seq      head frame (channel 0 in LSBs) and its sequence number
//   frame_valid/ready   downstream handshake
//   overrun_count       frames dropped on a full FIFO (saturating)
//   timeout_count       frames aborted for missing samples (saturating)
//   missed_count        triggers skipped while still collecting (saturating)
//   active              sequencer is not IDLE
module adc_frame_sequencer
    import adc_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DATA_W     = ADC_DATA_W,
    parameter int PERIOD_W   = 24,
    parameter int TIMEOUT    = 256,
    parameter int FIFO_DEPTH = 4,
    parameter int SEQ_W      = 16
) (
    input  logic                   clk,
    input  logic                   sresetn,
    input  logic                   enable,
    input  logic [PERIOD_W-1:0]    sample_period,
    output logic                   conv_req,
    input  logic [DATA_W-1:0]      sample_data,
    input  logic                   sample_valid,
    output logic [N_CH*DATA_W-1:0] frame_data,
    output logic [SEQ_W-1:0]       frame_seq,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic [15:0]            overrun_count,
    output logic [15:0]            timeout_count,
    output logic [15:0]            missed_count,
    output logic                   active
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int FW    = SEQ_W + N_CH * DATA_W;

    seq_state_t                     state, state_next;
    logic [PERIOD_W-1:0]            timer;
    logic [PERIOD_W-1:0]            period_m1;
    logic                           first;
    logic [CH_W-1:0]                ch_idx;
    logic [TMO_W-1:0]               tmo;
    logic [N_CH-1:0][DATA_W-1:0]    slots;
    logic [N_CH-1:0][DATA_W-1:0]    frame_slots;
    logic [SEQ_W-1:0]               seq;
    logic                           timer_hit;
    logic                           sample_last;
    logic                           tmo_hit;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic                           fifo_pop;
    logic [FW-1:0]                  fifo_rdata;

    assign period_m1   = (sample_period < PERIOD_W'(2)) ? PERIOD_W'(1)
                                                        : sample_period - PERIOD_W'(1);
    // >= rather than == so a period shortened on the fly still fires.
    assign timer_hit   = (timer >= period_m1);
    assign sample_last = (state == COLLECT) && sample_valid
                         && (ch_idx == CH_W'(N_CH - 1));
    // A final sample arriving in the last allowed cycle still wins.
    assign tmo_hit     = (state == COLLECT) && !sample_last
                         && (tmo == TMO_W'(TIMEOUT - 1));
    assign active      = (state != IDLE);

    // Slots with the current sample merged in, so the completing sample can
    // be pushed in the same cycle it arrives.
    always_comb begin
        frame_slots = slots;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_idx == CH_W'(c)) frame_slots[c] = sample_data;
        end
    end

    always_comb begin
        state_next = state;
        conv_req   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_next = ARMED;
            end
            ARMED: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (first || timer_hit) begin
                    conv_req   = 1'b1;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (sample_last || tmo_hit) state_next = enable ? ARMED : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state         <= IDLE;
            timer         <= '0;
            first         <= 1'b0;
            ch_idx        <= '0;
            tmo           <= '0;
            slots         <= '0;
            seq           <= '0;
            overrun_count <= '0;
            timeout_count <= '0;
            missed_count  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    timer <= '0;
                    first <= 1'b1;
                end
                ARMED: begin
                    if (conv_req) begin
                        timer  <= '0;
                        first  <= 1'b0;
                        ch_idx <= '0;
                        tmo    <= '0;
                    end else begin
                        timer <= timer + PERIOD_W'(1);
                    end
                end
                COLLECT: begin
                    // Period keeps running so spacing is conv_req to conv_req.
                    timer <= timer_hit ? '0 : timer + PERIOD_W'(1);
                    tmo   <= tmo + TMO_W'(1);
                    if (timer_hit) missed_count <= sat_inc16(missed_count);
                    if (sample_valid) begin
                        slots  <= frame_slots;
                        ch_idx <= ch_idx + CH_W'(1);
                    end
                    if (sample_last) begin
                        // Dropped frames still consume a number: visible gap.
                        seq <= seq + SEQ_W'(1);
                        if (fifo_full && !fifo_pop)
                            overrun_count <= sat_inc16(overrun_count);
                    end
                    if (tmo_hit) timeout_count <= sat_inc16(timeout_count);
                end
                default: ;
            endcase
        end
    end

    assign fifo_pop = !fifo_empty && frame_ready;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .sresetn (sresetn),
        .push    (sample_last),
        .wdata   ({seq, frame_slots}),
        .pop     (fifo_pop),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign frame_valid = !fifo_empty;
    assign frame_data  = fifo_empty ? '0 : fifo_rdata[N_CH*DATA_W-1:0];
    assign frame_seq   = fifo_empty ? '0 : fifo_rdata[FW-1 -: SEQ_W];

endmodule

// File: tb/tb_adc_frame_sequencer.sv
module tb_adc_frame_sequencer;

    logic        clk;
    logic        sresetn;
    logic        enable;
    logic [23:0] sample_period;
    logic        conv_req;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic [63:0] frame_data;
    logic [15:0] frame_seq;
    logic        frame_valid;
    logic        frame_ready;
    logic [15:0] overrun_count, timeout_count, missed_count;
    logic        active;

    // Second instance: one channel, 2-bit sequence, for period floor and wrap.
    logic        en2;
    logic [7:0]  per2;
    logic        conv2;
    logic [15:0] fd2;
    logic [1:0]  fs2;
    logic        fv2;
    logic [15:0] oc2, tc2, mc2;
    logic        act2;

    int checks = 0;
    int errors = 0;

    adc_frame_sequencer dut (
        .clk           (clk),
        .sresetn       (sresetn),
        .enable        (enable),
        .sample_period (sample_period),
        .conv_req      (conv_req),
        .sample_data   (sample_data),
        .sample_valid  (sample_valid),
        .frame_data    (frame_data),
        .frame_seq     (frame_seq),
        .frame_valid   (frame_valid),
        .frame_ready   (frame_ready),
        .overrun_count (overrun_count),
        .timeout_count (timeout_count),
        .missed_count  (missed_count),
        .active        (active)
    );

    adc_frame_sequencer #(
        .N_CH       (1),
        .PERIOD_W   (8),
        .TIMEOUT    (8),
        .FIFO_DEPTH (2),
        .SEQ_W      (2)
    ) dut2 (
        .clk           (clk),
        .sresetn       (sresetn),
        .enable        (en2),
        .sample_period (per2),
        .conv_req      (conv2),
        .sample_data   (16'hABCD),
        .sample_valid  (1'b1),
        .frame_data    (fd2),
        .frame_seq     (fs2),
        .frame_valid   (fv2),
        .frame_ready   (1'b1),
        .overrun_count (oc2),
        .timeout_count (tc2),
        .missed_count  (mc2),
        .active        (act2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_conv(input int limit, output int waited);
        waited = 0;
        while (conv_req !== 1'b1 && waited < limit) begin
            tick();
            waited++;
        end
    endtask

    // Driver model: after 'delay' clocks, stream nsamp samples back to back.
    task automatic send_frame(input int delay, input int nsamp, input logic [63:0] vals,
                              input logic rdy_last, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < delay; i++) begin
            tick();
            seen |= conv_req;
        end
        for (int i = 0; i < nsamp; i++) begin
            sample_valid = 1'b1;
            sample_data  = vals[16*i +: 16];
            if (rdy_last && i == nsamp - 1) frame_ready = 1'b1;
            tick();
            seen |= conv_req;
        end
        sample_valid = 1'b0;
        if (rdy_last) frame_ready = 1'b0;
    endtask

    task automatic do_reset();
        sresetn      = 1'b0;
        enable       = 1'b0;
        sample_valid = 1'b0;
        frame_ready  = 1'b0;
        tick();
        tick();
        sresetn = 1'b1;
    endtask

    function automatic logic [63:0] mk(input int f);
        return 64'h0004_0003_0002_0001 + 64'(f) * 64'h0010_0010_0010_0010;
    endfunction

    localparam logic [63:0] BASIC = 64'h4444_3333_2222_1111;

    int   w;
    int   k;
    logic seen;

    initial begin
        sresetn = 1'b0; enable = 1'b0; sample_period = 24'd100;
        sample_data = 16'h0; sample_valid = 1'b0; frame_ready = 1'b0;
        en2 = 1'b0; per2 = 8'd0;
        tick(); tick();

        // Reset state
        chk("rst_conv", conv_req, 0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_fd", frame_data, 0);
        chk("rst_seq", frame_seq, 0);
        chk("rst_cnt", {overrun_count, timeout_count, missed_count}, 0);
        chk("rst_active", active, 0);
        sresetn = 1'b1;

        // Basic frames, consumer always ready
        sample_period = 24'd100; frame_ready = 1'b1; enable = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_conv(200, w);
            chk("basic_gap", w, (f == 0) ? 1 : 76);
            send_frame(20, 4, BASIC, 1'b0, seen);
            chk("basic_fv", frame_valid, 1);
            chk("basic_data", frame_data, BASIC);
            chk("basic_seq", frame_seq, f);
        end
        chk("basic_cnt", {overrun_count, timeout_count, missed_count}, 0);

        // Backpressure and overrun
        do_reset();
        sample_period = 24'd100; enable = 1'b1;
        for (int f = 0; f < 6; f++) begin
            wait_conv(200, w);
            send_frame(20, 4, mk(f), 1'b0, seen);
            if (f == 0) chk("ovr_fv_first", frame_valid, 1);
        end
        chk("ovr_count", overrun_count, 2);
        chk("ovr_head_seq", frame_seq, 0);
        enable = 1'b0;
        tick(); tick(); tick();
        chk("ovr_stable_data", frame_data, mk(0));
        chk("ovr_stable_seq", frame_seq, 0);
        frame_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            chk("drain_fv", frame_valid, 1);
            chk("drain_seq", frame_seq, f);
            chk("drain_data", frame_data, mk(f));
            tick();
        end
        chk("drain_empty", frame_valid, 0);

        // Timeout: only three samples delivered
        do_reset();
        sample_period = 24'd100; frame_ready = 1'b1; enable = 1'b1;
        wait_conv(200, w);
        send_frame(20, 3, BASIC, 1'b0, seen);
        wait_conv(400, w);
        chk("tmo_next_conv", w, 277);
        chk("tmo_no_frame", frame_valid, 0);
        send_frame(20, 4, BASIC, 1'b0, seen);
        chk("tmo_fv", frame_valid, 1);
        chk("tmo_seq_kept", frame_seq, 0);
        chk("tmo_count", timeout_count, 1);
        chk("tmo_missed", missed_count, 2);

        // Missed triggers: period 10, samples 15 clocks late
        do_reset();
        sample_period = 24'd10; enable = 1'b1;
        wait_conv(20, w);
        chk("miss_first", w, 1);
        send_frame(15, 4, mk(0), 1'b0, seen);
        chk("miss_noreq1", seen, 0);
        chk("miss_cnt1", missed_count, 1);
        wait_conv(40, w);
        chk("miss_gap", w, 1);
        send_frame(15, 4, mk(1), 1'b0, seen);
        chk("miss_noreq2", seen, 0);
        chk("miss_cnt2", missed_count, 2);
        chk("miss_queued", frame_valid, 1);

        // Reset with two frames queued
        sresetn = 1'b0; enable = 1'b0;
        tick();
        chk("mid_rst_fv", frame_valid, 0);
        chk("mid_rst_cnt", {overrun_count, timeout_count, missed_count}, 0);
        chk("mid_rst_active", active, 0);
        chk("mid_rst_conv", conv_req, 0);
        sresetn = 1'b1;
        tick();

        // Enable dropped mid-collect
        sample_period = 24'd100; frame_ready = 1'b1; enable = 1'b1;
        wait_conv(10, w);
        tick();
        enable = 1'b0;
        send_frame(19, 4, BASIC, 1'b0, seen);
        chk("dis_active", active, 0);
        chk("dis_fv", frame_valid, 1);
        chk("dis_data", frame_data, BASIC);
        wait_conv(150, w);
        chk("dis_no_conv", w, 150);

        // Push and pop together on a full FIFO
        do_reset();
        sample_period = 24'd100; enable = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_conv(200, w);
            send_frame(20, 4, mk(f), 1'b0, seen);
        end
        wait_conv(200, w);
        send_frame(20, 4, mk(4), 1'b1, seen);
        chk("pp_overrun", overrun_count, 0);
        chk("pp_fv", frame_valid, 1);
        chk("pp_head_seq", frame_seq, 1);
        chk("pp_head_data", frame_data, mk(1));
        enable = 1'b0;

        // Period floor (0 then 1) and 2-bit sequence wrap on the second instance
        per2 = 8'd0; en2 = 1'b1;
        tick();
        k = 0;
        for (int i = 0; i < 20; i++) begin
            chk("p2_conv", conv2, (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("p2_fv", fv2, (i >= 2 && i % 2 == 0) ? 64'd1 : 64'd0);
            if (fv2) begin
                chk("p2_seq", fs2, 64'(k % 4));
                k++;
            end
            if (i == 10) per2 = 8'd1;
            tick();
        end
        chk("p2_frames", k, 9);
        chk("p2_data", fd2, 16'hABCD);
        chk("p2_missed", mc2, 0);
        en2 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
